// File: rtl/idexe_pkg.sv
// -----------------------------------------------------------------------------
// idexe_pkg
// Shared types and constants for the ARQ-bit ID/EXE pipeline register and its
// hazard unit.
//   ctrl_t        : 8-bit decoded control bundle carried from ID to EXE
//   shadow_t      : one in-flight instruction as seen by hazard detection
//   FWD_*         : operand-forwarding select encodings
//   *_BUBBLE      : contents of an empty pipeline slot
//   src_match()   : "this source reads the register this entry will write"
// -----------------------------------------------------------------------------
package idexe_pkg;

  typedef struct packed {
    logic wb_en;
    logic rd_mem_en;
    logic wr_mem_en;
    logic mux_exe;
    logic mux_mem;
    logic jop_lsb;
    logic jenable;
    logic pc_en;
  } ctrl_t;

  // Shadow entries store rd at a fixed width so the type can live here;
  // register indices up to SHADOW_RD_W bits are zero-extended into it.
  localparam int SHADOW_RD_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [SHADOW_RD_W-1:0] rd;
    logic                   wb_en;
    logic                   load;
  } shadow_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam ctrl_t   CTRL_BUBBLE   = '0;
  localparam shadow_t SHADOW_BUBBLE = '0;

  // R0 is an ordinary register here, so index 0 matches like any other.
  function automatic logic src_match(shadow_t e, logic used,
                                     logic [SHADOW_RD_W-1:0] idx);
    return used && e.valid && e.wb_en && (e.rd == idx);
  endfunction

endpackage

// File: rtl/idexe_hazard_unit.sv
// -----------------------------------------------------------------------------
// idexe_hazard_unit
// Purely combinational RAW-hazard detection and forwarding-select generation.
// Compares the ID-stage source indices with the three shadow entries
// (EXE, MEM, WB).
//
// Configuration macro: IDEXE_FWD_EN
//   defined   : stall only on load-use against EXE; fwd_sel picks the
//               youngest matching producer (EXE -> MEM result next cycle,
//               MEM -> WB result next cycle).
//   undefined : any match in EXE/MEM/WB stalls; fwd_sel is always FWD_RF.
//
// Ports:
//   id_valid            in   ID holds a real instruction
//   flush               in   EXE resolved a taken branch (squashes ID)
//   rs1, rs2            in   source register indices
//   rs1_used, rs2_used  in   source actually read
//   sh_exe/sh_mem/sh_wb in   shadow pipeline entries
//   stall               out  hold PC and IF/ID this cycle
//   fwd_sel1, fwd_sel2  out  operand source selects for the ID instruction
// -----------------------------------------------------------------------------
module idexe_hazard_unit
  import idexe_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              id_valid,
  input  logic              flush,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  shadow_t           sh_exe,
  input  shadow_t           sh_mem,
  input  shadow_t           sh_wb,
  output logic              stall,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2
);

  logic [SHADOW_RD_W-1:0] rs1_ext;
  logic [SHADOW_RD_W-1:0] rs2_ext;
  logic m1_exe, m1_mem, m1_wb;
  logic m2_exe, m2_mem, m2_wb;
  logic raw_hazard;

  assign rs1_ext = SHADOW_RD_W'(rs1);
  assign rs2_ext = SHADOW_RD_W'(rs2);

  assign m1_exe = src_match(sh_exe, rs1_used, rs1_ext);
  assign m1_mem = src_match(sh_mem, rs1_used, rs1_ext);
  assign m1_wb  = src_match(sh_wb,  rs1_used, rs1_ext);
  assign m2_exe = src_match(sh_exe, rs2_used, rs2_ext);
  assign m2_mem = src_match(sh_mem, rs2_used, rs2_ext);
  assign m2_wb  = src_match(sh_wb,  rs2_used, rs2_ext);

`ifdef IDEXE_FWD_EN
  // Only a load in EXE has no result to forward yet; everything else is
  // bypassed. A WB-stage producer is read through the register file.
  logic unused_wb_match;
  assign unused_wb_match = m1_wb | m2_wb;

  assign raw_hazard = sh_exe.load && (m1_exe || m2_exe);
  assign fwd_sel1   = m1_exe ? FWD_MEM : (m1_mem ? FWD_WB : FWD_RF);
  assign fwd_sel2   = m2_exe ? FWD_MEM : (m2_mem ? FWD_WB : FWD_RF);
`else
  assign raw_hazard = m1_exe || m1_mem || m1_wb || m2_exe || m2_mem || m2_wb;
  assign fwd_sel1   = FWD_RF;
  assign fwd_sel2   = FWD_RF;
`endif

  // A squashed or empty ID slot must never hold the front end.
  assign stall = id_valid && !flush && raw_hazard;

endmodule

// File: rtl/idexe_hazard_pipe.sv
// -----------------------------------------------------------------------------
// idexe_hazard_pipe
// ID/EXE pipeline register for the ARQ-bit core with valid tracking, bubble
// insertion, branch flush, RAW-hazard stall, forwarding selects and a
// saturating stall counter. Forwarding behaviour is selected inside
// idexe_hazard_unit by the IDEXE_FWD_EN macro.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   id_*                      decoded instruction from ID
//   exe_branch_taken          EXE resolved a taken branch: flush ID
//   exe_*                     registered instruction presented to EXE
//   fwd_sel1, fwd_sel2        registered operand source selects
//   stall_out                 combinational hold for PC and IF/ID
//   stall_cnt                 saturating count of stall cycles
// -----------------------------------------------------------------------------
module idexe_hazard_pipe
  import idexe_pkg::*;
#(
  parameter int ARQ    = 16,
  parameter int ADDR_W = 13,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  ctrl_t             id_ctrl,
  input  logic [ARQ-1:0]    id_src1,
  input  logic [ARQ-1:0]    id_src2,
  input  logic [ARQ-1:0]    id_src3,
  input  logic [ARQ-1:0]    id_imm,
  input  logic [1:0]        id_alu_op,
  input  logic [ADDR_W-1:0] id_jaddr,
  input  logic              exe_branch_taken,
  output logic              exe_valid,
  output logic [REG_AW-1:0] exe_rd,
  output ctrl_t             exe_ctrl,
  output logic [ARQ-1:0]    exe_src1,
  output logic [ARQ-1:0]    exe_src2,
  output logic [ARQ-1:0]    exe_src3,
  output logic [ARQ-1:0]    exe_imm,
  output logic [1:0]        exe_alu_op,
  output logic [ADDR_W-1:0] exe_jaddr,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic              stall_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  shadow_t    sh_exe, sh_mem, sh_wb;
  logic       stall;
  logic       capture;
  logic [1:0] fwd1_d, fwd2_d;

  // The EXE shadow entry is a view of the output register, so it can never
  // disagree with what EXE is actually executing.
  assign sh_exe = '{valid: exe_valid,
                    rd:    SHADOW_RD_W'(exe_rd),
                    wb_en: exe_ctrl.wb_en,
                    load:  exe_ctrl.rd_mem_en};

  idexe_hazard_unit #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .id_valid (id_valid),
    .flush    (exe_branch_taken),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .sh_exe   (sh_exe),
    .sh_mem   (sh_mem),
    .sh_wb    (sh_wb),
    .stall    (stall),
    .fwd_sel1 (fwd1_d),
    .fwd_sel2 (fwd2_d)
  );

  assign stall_out = stall;

  // Flush, stall and an empty ID slot all resolve to a bubble; stall is
  // already masked by flush inside the hazard unit.
  assign capture = id_valid && !exe_branch_taken && !stall;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // Data fields are reset too: a bubble must present all-zero contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_valid  <= 1'b0;
      exe_rd     <= '0;
      exe_ctrl   <= CTRL_BUBBLE;
      exe_src1   <= '0;
      exe_src2   <= '0;
      exe_src3   <= '0;
      exe_imm    <= '0;
      exe_alu_op <= '0;
      exe_jaddr  <= '0;
      fwd_sel1   <= FWD_RF;
      fwd_sel2   <= FWD_RF;
    end else if (capture) begin
      exe_valid  <= 1'b1;
      exe_rd     <= id_rd;
      exe_ctrl   <= id_ctrl;
      exe_src1   <= id_src1;
      exe_src2   <= id_src2;
      exe_src3   <= id_src3;
      exe_imm    <= id_imm;
      exe_alu_op <= id_alu_op;
      exe_jaddr  <= id_jaddr;
      fwd_sel1   <= fwd1_d;
      fwd_sel2   <= fwd2_d;
    end else begin
      exe_valid  <= 1'b0;
      exe_rd     <= '0;
      exe_ctrl   <= CTRL_BUBBLE;
      exe_src1   <= '0;
      exe_src2   <= '0;
      exe_src3   <= '0;
      exe_imm    <= '0;
      exe_alu_op <= '0;
      exe_jaddr  <= '0;
      fwd_sel1   <= FWD_RF;
      fwd_sel2   <= FWD_RF;
    end
  end

  // MEM and WB advance every cycle; a stall only holds the front end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_mem <= SHADOW_BUBBLE;
      sh_wb  <= SHADOW_BUBBLE;
    end else begin
      sh_mem <= sh_exe;
      sh_wb  <= sh_mem;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_idexe_hazard_pipe.sv
module tb_idexe_hazard_pipe;
  import idexe_pkg::*;

  localparam int ARQ    = 16;
  localparam int ADDR_W = 13;
  localparam int REG_AW = 4;
  localparam int CNT_W  = 4;   // small so saturation is reachable
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int BW = 1 + REG_AW + 8 + 4*ARQ + 2 + ADDR_W;
`ifdef IDEXE_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic              clk, rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_rs1_used, id_rs2_used;
  ctrl_t             id_ctrl;
  logic [ARQ-1:0]    id_src1, id_src2, id_src3, id_imm;
  logic [1:0]        id_alu_op;
  logic [ADDR_W-1:0] id_jaddr;
  logic              exe_branch_taken;
  logic              exe_valid;
  logic [REG_AW-1:0] exe_rd;
  ctrl_t             exe_ctrl;
  logic [ARQ-1:0]    exe_src1, exe_src2, exe_src3, exe_imm;
  logic [1:0]        exe_alu_op;
  logic [ADDR_W-1:0] exe_jaddr;
  logic [1:0]        fwd_sel1, fwd_sel2;
  logic              stall_out;
  logic [CNT_W-1:0]  stall_cnt;

  idexe_hazard_pipe #(
    .ARQ(ARQ), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_ctrl(id_ctrl),
    .id_src1(id_src1), .id_src2(id_src2), .id_src3(id_src3), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_jaddr(id_jaddr),
    .exe_branch_taken(exe_branch_taken),
    .exe_valid(exe_valid), .exe_rd(exe_rd), .exe_ctrl(exe_ctrl),
    .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_src3(exe_src3),
    .exe_imm(exe_imm), .exe_alu_op(exe_alu_op), .exe_jaddr(exe_jaddr),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_out(stall_out), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              rs1_used, rs2_used;
    ctrl_t             ctrl;
    logic [ARQ-1:0]    src1, src2, src3, imm;
    logic [1:0]        alu_op;
    logic [ADDR_W-1:0] jaddr;
  } instr_t;

  // One instruction in flight after ID; age 0 = EXE, 1 = MEM, 2 = WB.
  typedef struct {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              writes;
    logic              is_load;
  } flight_t;

  flight_t          hist[$];
  logic [CNT_W-1:0] m_cnt;
  int               checks = 0;
  int               passes = 0;

  // ---------------------------------------------------------------- model
  function automatic bit reads_result(flight_t f, logic used, logic [REG_AW-1:0] idx);
    return used && f.valid && f.writes && (f.rd == idx);
  endfunction

  function automatic logic model_stall(instr_t in, logic br);
    bit hz = 0;
    if (!in.valid || br) return 1'b0;
    if (FWD_ON) begin
      hz = hist[0].is_load &&
           (reads_result(hist[0], in.rs1_used, in.rs1) ||
            reads_result(hist[0], in.rs2_used, in.rs2));
    end else begin
      foreach (hist[a])
        if (reads_result(hist[a], in.rs1_used, in.rs1) ||
            reads_result(hist[a], in.rs2_used, in.rs2)) hz = 1;
    end
    return hz;
  endfunction

  function automatic logic [1:0] model_fwd(logic used, logic [REG_AW-1:0] idx);
    if (FWD_ON && reads_result(hist[0], used, idx)) return 2'b01;
    if (FWD_ON && reads_result(hist[1], used, idx)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [BW-1:0] pack_in(instr_t in);
    return {1'b1, in.rd, in.ctrl, in.src1, in.src2, in.src3, in.imm, in.alu_op, in.jaddr};
  endfunction

  function automatic logic [BW-1:0] pack_out();
    return {exe_valid, exe_rd, exe_ctrl, exe_src1, exe_src2, exe_src3, exe_imm,
            exe_alu_op, exe_jaddr};
  endfunction

  task automatic model_clear();
    flight_t e;
    e = '{valid: 1'b0, rd: '0, writes: 1'b0, is_load: 1'b0};
    hist.delete();
    repeat (3) hist.push_back(e);
    m_cnt = '0;
  endtask

  // ------------------------------------------------------------ stimulus
  function automatic instr_t mk(logic [REG_AW-1:0] rd, logic [REG_AW-1:0] rs1,
                                logic [REG_AW-1:0] rs2, logic u1, logic u2,
                                logic wb, logic ld);
    instr_t in;
    in.valid = 1'b1;
    in.rd = rd; in.rs1 = rs1; in.rs2 = rs2;
    in.rs1_used = u1; in.rs2_used = u2;
    in.ctrl = ctrl_t'($urandom);
    in.ctrl.wb_en = wb;
    in.ctrl.rd_mem_en = ld;
    in.src1 = ARQ'($urandom); in.src2 = ARQ'($urandom);
    in.src3 = ARQ'($urandom); in.imm  = ARQ'($urandom);
    in.alu_op = 2'($urandom);
    in.jaddr = ADDR_W'($urandom);
    return in;
  endfunction

  function automatic instr_t idle();
    instr_t in;
    in = mk('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    in.valid = 1'b0;
    return in;
  endfunction

  task automatic drive(instr_t in, logic br);
    id_valid = in.valid; id_rs1 = in.rs1; id_rs2 = in.rs2; id_rd = in.rd;
    id_rs1_used = in.rs1_used; id_rs2_used = in.rs2_used; id_ctrl = in.ctrl;
    id_src1 = in.src1; id_src2 = in.src2; id_src3 = in.src3; id_imm = in.imm;
    id_alu_op = in.alu_op; id_jaddr = in.jaddr;
    exe_branch_taken = br;
  endtask

  // One clock: present ID, check stall_out, clock it, check EXE side.
  // Must be entered at least 2 time units before a rising edge.
  task automatic step(instr_t in, logic br, output logic obs_stall);
    logic          exp_stall, cap;
    logic [1:0]    ef1, ef2;
    logic [BW-1:0] exp_bus;
    flight_t       nf;
    drive(in, br);
    #2;
    exp_stall = model_stall(in, br);
    obs_stall = stall_out;
    checks++;
    if (stall_out !== exp_stall)
      $display("FAIL stall_out got=%b exp=%b t=%0t", stall_out, exp_stall, $time);
    else passes++;
    cap = in.valid && !br && !exp_stall;
    ef1 = cap ? model_fwd(in.rs1_used, in.rs1) : 2'b00;
    ef2 = cap ? model_fwd(in.rs2_used, in.rs2) : 2'b00;
    exp_bus = cap ? pack_in(in) : '0;
    @(posedge clk);
    #1;
    checks++;
    if (pack_out() !== exp_bus)
      $display("FAIL exe_fields got=%h exp=%h t=%0t", pack_out(), exp_bus, $time);
    else passes++;
    checks++;
    if ({fwd_sel1, fwd_sel2} !== {ef1, ef2})
      $display("FAIL fwd_sel got=%b_%b exp=%b_%b t=%0t", fwd_sel1, fwd_sel2, ef1, ef2, $time);
    else passes++;
    nf = '{valid: cap, rd: cap ? in.rd : '0, writes: cap & in.ctrl.wb_en,
           is_load: cap & in.ctrl.rd_mem_en};
    hist.push_front(nf);
    void'(hist.pop_back());
    if (exp_stall && m_cnt != CNT_MAX) m_cnt++;
    checks++;
    if (stall_cnt !== m_cnt)
      $display("FAIL stall_cnt got=%0d exp=%0d t=%0t", stall_cnt, m_cnt, $time);
    else passes++;
  endtask

  // Hold an instruction in ID until it is accepted (bounded).
  task automatic issue(instr_t in, output int stalls, output logic [1:0] f1, output logic [1:0] f2);
    logic s;
    stalls = 0;
    s = 1'b1;
    for (int k = 0; k < 8 && s; k++) begin
      step(in, 1'b0, s);
      if (s) stalls++;
    end
    f1 = fwd_sel1;
    f2 = fwd_sel2;
    checks++;
    if (s !== 1'b0) $display("FAIL issue_bound still stalled after 8 cycles");
    else passes++;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive(idle(), 1'b0);
    #7;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b0;
    drive(idle(), 1'b0);
    #22;
    checks++;
    if ({pack_out(), fwd_sel1, fwd_sel2, stall_out, stall_cnt} !== '0)
      $display("FAIL reset_state got=%h exp=0", {pack_out(), fwd_sel1, fwd_sel2, stall_out, stall_cnt});
    else passes++;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    checks++;
    if ({exe_valid, stall_out, stall_cnt} !== '0)
      $display("FAIL reset_release got=%b_%b_%0d exp=0_0_0", exe_valid, stall_out, stall_cnt);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic s;
    int   n = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(mk(REG_AW'(8 + i), 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, s);
      if (s) n++;
      checks++;
      if (exe_valid !== 1'b1) $display("FAIL b2b_valid got=%b exp=1", exe_valid);
      else passes++;
    end
    checks++;
    if (n != 0) $display("FAIL b2b_stalls got=%0d exp=0", n);
    else passes++;
  endtask

  task automatic test_load_use();
    logic s;
    int st;
    logic [1:0] f1, f2;
    apply_reset();
    step(mk(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0, s);
    issue(mk(4'd6, 4'd3, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0), st, f1, f2);
    checks++;
    if (st != (FWD_ON ? 1 : 3)) $display("FAIL lu_stalls got=%0d exp=%0d", st, FWD_ON ? 1 : 3);
    else passes++;
    checks++;
    if (f1 !== (FWD_ON ? 2'b10 : 2'b00)) $display("FAIL lu_fwd1 got=%b exp=%b", f1, FWD_ON ? 2'b10 : 2'b00);
    else passes++;
    checks++;
    if (stall_cnt !== CNT_W'(FWD_ON ? 1 : 3)) $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, FWD_ON ? 1 : 3);
    else passes++;
  endtask

  task automatic test_alu_fwd();
    logic s;
    int st;
    logic [1:0] f1, f2;
    apply_reset();
    step(mk(4'd5, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, s);
    issue(mk(4'd9, 4'd0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0), st, f1, f2);
    checks++;
    if (st != (FWD_ON ? 0 : 3) || f2 !== (FWD_ON ? 2'b01 : 2'b00))
      $display("FAIL alu_adj got=%0d/%b exp=%0d/%b", st, f2, FWD_ON ? 0 : 3, FWD_ON ? 2'b01 : 2'b00);
    else passes++;
    checks++;
    if (stall_cnt !== CNT_W'(FWD_ON ? 0 : 3)) $display("FAIL alu_cnt got=%0d exp=%0d", stall_cnt, FWD_ON ? 0 : 3);
    else passes++;
    apply_reset();
    step(mk(4'd5, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, s);
    step(mk(4'd10, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0, s);
    issue(mk(4'd11, 4'd0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0), st, f1, f2);
    checks++;
    if (st != (FWD_ON ? 0 : 2) || f2 !== (FWD_ON ? 2'b10 : 2'b00))
      $display("FAIL alu_gap got=%0d/%b exp=%0d/%b", st, f2, FWD_ON ? 0 : 2, FWD_ON ? 2'b10 : 2'b00);
    else passes++;
  endtask

  task automatic test_flush();
    logic s;
    logic [CNT_W-1:0] c0;
    apply_reset();
    step(mk(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0, s);
    c0 = stall_cnt;
    step(mk(4'd6, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, s);
    checks++;
    if (s !== 1'b0 || exe_valid !== 1'b0 || stall_cnt !== c0)
      $display("FAIL flush got=%b_%b_%0d exp=0_0_%0d", s, exe_valid, stall_cnt, c0);
    else passes++;
  endtask

  task automatic test_reset_mid_stall();
    logic s;
    instr_t dep;
    apply_reset();
    step(mk(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0, s);
    dep = mk(4'd6, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(dep, 1'b0);
    #2;
    checks++;
    if (stall_out !== 1'b1) $display("FAIL pre_rst_stall got=%b exp=1", stall_out);
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if ({pack_out(), fwd_sel1, fwd_sel2, stall_out, stall_cnt} !== '0)
      $display("FAIL async_reset got=%h exp=0", {pack_out(), fwd_sel1, fwd_sel2, stall_out, stall_cnt});
    else passes++;
    #1;
    rst = 1'b1;
    model_clear();
    step(dep, 1'b0, s);
    checks++;
    if (s !== 1'b0 || exe_valid !== 1'b1) $display("FAIL post_rst got=%b_%b exp=0_1", s, exe_valid);
    else passes++;
  endtask

  task automatic test_saturation();
    int st;
    logic s;
    logic [1:0] f1, f2;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step(mk(4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1), 1'b0, s);
      issue(mk(4'd7, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0), st, f1, f2);
    end
    checks++;
    if (stall_cnt !== CNT_MAX) $display("FAIL saturate got=%0d exp=%0d", stall_cnt, CNT_MAX);
    else passes++;
  endtask

  task automatic test_random();
    instr_t cur;
    logic s, br;
    apply_reset();
    s = 1'b0;
    br = 1'b0;
    cur = idle();
    for (int i = 0; i < 400; i++) begin
      if (!s || br) begin
        cur = mk(REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
                 REG_AW'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) < 2));
        cur.valid = ($urandom_range(0, 9) != 0);
      end
      br = ($urandom_range(0, 7) == 0);
      step(cur, br, s);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_alu_fwd();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
